// File: rtl/seq_factorial.sv
`timescale 1ns/1ps
// seq_factorial: multi-cycle factorial engine, one RES_W x N_W multiply per
// clock. Result is n! mod 2^RES_W with a sticky overflow flag. The done pulse
// and the result/overflow outputs are registered, so they appear one cycle
// after the FSM reaches DONE.
module seq_factorial #(
  parameter int N_W   = 8,
  parameter int RES_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_W-1:0]   n_in,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             overflow
);

  localparam int P_W = RES_W + N_W;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [RES_W-1:0] acc;
  logic [N_W-1:0]   cnt;
  logic             ovf_s;
  logic             done_nxt;
  logic [P_W-1:0]   prod;
  logic             cnt_gt1;
  logic             accept;

  // Full-width product of the running accumulator and the down-counter.
  function automatic logic [P_W-1:0] full_product(input logic [RES_W-1:0] a,
                                                   input logic [N_W-1:0]   b);
    logic [P_W-1:0] ae;
    logic [P_W-1:0] be;
    ae = {{N_W{1'b0}}, a};
    be = {{RES_W{1'b0}}, b};
    return ae * be;
  endfunction

  // True when the product no longer fits in RES_W bits.
  function automatic logic upper_nonzero(input logic [P_W-1:0] p);
    return |p[P_W-1:RES_W];
  endfunction

  assign prod    = full_product(acc, cnt);
  assign cnt_gt1 = (cnt > N_W'(1));
  // While the registered done pulse is still high the request window has not
  // reopened yet; this keeps the next acceptance at least two edges after DONE.
  assign accept  = (state == IDLE) && start && !done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (!cnt_gt1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    busy     = (state == CALC);
    done_nxt = (state == DONE);
  end

  // Datapath: operand capture and one multiply step per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= RES_W'(1);
      cnt   <= '0;
      ovf_s <= 1'b0;
    end else if (accept) begin
      acc   <= RES_W'(1);
      cnt   <= n_in;
      ovf_s <= 1'b0;
    end else if ((state == CALC) && cnt_gt1) begin
      acc   <= prod[RES_W-1:0];
      ovf_s <= ovf_s | upper_nonzero(prod);
      cnt   <= cnt - N_W'(1);
    end
  end

  // Registered completion outputs, held until the next done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      done <= done_nxt;
      if (done_nxt) begin
        result   <= acc;
        overflow <= ovf_s;
      end
    end
  end

endmodule

// File: doc/seq_factorial.md
# seq_factorial

Multi-cycle, parametrised factorial engine: accepts an operand `n` on a start handshake and computes `n!` with one multiply per clock instead of a combinational recursion. The result is saturation-free: the low `RES_W` bits are kept and a sticky overflow flag is raised. It sits in the functions/arithmetic library as the clocked successor of the combinational factorial function, for designs that need a bounded multiplier and a done/busy handshake.

## Interface
- `N_W`, default 8: operand width in bits.
- `RES_W`, default 64: result width in bits. Must be ≥ `N_W`.
- `clk` input, 1: clock, rising-edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start` input, 1: request. Sampled only in IDLE.
- `n_in` input, `N_W`: operand. Captured on the accepted `start` edge.
- `busy` output, 1: high while in CALC.
- `done` output, 1: one-cycle pulse when `result` and `overflow` become valid.
- `result` output, `RES_W`: `n!` mod 2^`RES_W`. Held until the next `done`.
- `overflow` output, 1: high if the true `n!` ≥ 2^`RES_W`. Held with `result`.

## Operation
- FSM states: IDLE, CALC, DONE.
- Internal registers:
  - `acc`, `RES_W` bits.
  - `cnt`, `N_W` bits.
  - `ovf_s`, sticky overflow.
- IDLE:
  - If `start`=1: capture `cnt`←`n_in`, `acc`←1, `ovf_s`←0, and move to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - If `cnt` > 1:
    - Form the full product `p` = `acc` × `cnt` (`RES_W`+`N_W` bits).
    - `acc`←`p`[`RES_W`-1:0].
    - `ovf_s`←`ovf_s` | (`p`[`RES_W`+`N_W`-1:`RES_W`] ≠ 0).
    - `cnt`←`cnt`−1.
  - If `cnt` ≤ 1: `result`←`acc`, `overflow`←`ovf_s`, and move to DONE.
- DONE: `done`=1 for exactly this cycle, then unconditionally return to IDLE.
- Truncating `acc` every step is exact modulo 2^`RES_W`, so `result` always equals `n!` mod 2^`RES_W`.
- There is no early exit on overflow. Latency depends only on `n`.
- `start` is ignored in CALC and in DONE. There is no queueing. A request must be re-presented in IDLE.
- `n_in` changes after acceptance have no effect.
- 0! = 1! = 1, with `overflow`=0.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, `overflow`=0, `acc`=1, `cnt`=0, `ovf_s`=0.
- Reset asserted mid-CALC aborts the computation immediately to the reset values. No `done` is produced for the aborted request.
- Edge numbering: edge 0 is the rising edge at which `start` is sampled in IDLE.
  - `busy` is high from after edge 0 until edge max(`n`,1).
  - `done`, `result` and `overflow` update after edge max(`n`,1)+1.
  - Latency from `start` to `done` = max(`n`,1)+1 cycles.
- Earliest next accepted `start` is at edge max(`n`,1)+3.
- `result` and `overflow` are registered outputs, stable from the `done` cycle until the next `done`.
- Combinational path per cycle: one `RES_W`×`N_W` multiply plus the upper-bits OR reduce.

## Test plan
- Basic case, defaults: `n_in`=5, `start` pulse → `done` 6 cycles after acceptance, `result`=120, `overflow`=0, `busy` high for 5 cycles.
- Edge operands:
  - `n`=0 → `result`=1, `overflow`=0, latency 2.
  - `n`=1 → `result`=1, `overflow`=0, latency 2.
  - `n`=2 → `result`=2, `overflow`=0, latency 3.
- Width boundary:
  - `n`=20 → `result`=2432902008176640000, `overflow`=0.
  - `n`=21 → `result`=14197454024290336768, `overflow`=1.
  - Then `n`=3 → `result`=6, `overflow`=0, confirming the sticky flag is cleared per request.
- Handshake:
  - Start `n`=6. Hold `start` high and change `n_in` to 9 during CALC and DONE.
  - Expect exactly one `done` with `result`=720.
  - The held `start` is accepted in the following IDLE cycle. The second `done` gives 362880.
- Reset mid-operation:
  - Start `n`=10. Assert `rst_n`=0 asynchronously at cycle 4.
  - All outputs go to reset values immediately, with no `done`.
  - After release, `n`=4 → `result`=24.
- Parameter sweep:
  - `N_W`=4, `RES_W`=16, all `n` 0..15, checked against a reference model of `n`! mod 65536 and the overflow flag.
  - The first overflow is at `n`=9.
